// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared state encoding, anode constant and leading-zero mask helper
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_GUARD = 1'b1
    } state_e;

    localparam logic [7:0] AN_OFF = 8'hFF;

    // Keep digit i only if enabled and some nibble at or above it is nonzero; digit 0 always survives
    function automatic logic [7:0] lz_mask(input logic [31:0] d, input logic [7:0] en);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = en[i] & ((i == 0) || ((d >> (4 * i)) != 32'd0));
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: CPU-side load bus and board-side display pins of the scan controller
interface seg_scan_ctrl_if;
    logic [31:0] data;
    logic        load;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (output data, load, digit_en, dp_in, input an, seg, dp, frame_tick);
    modport slave  (input data, load, digit_en, dp_in, output an, seg, dp, frame_tick);
endinterface

// File: rtl/seg_scan_ctrl_sevensegs.sv
// SevenSegs: hex nibble to active-high segment pattern (bit0 = a .. bit6 = g), blank when disabled
module SevenSegs (
    input  logic [3:0] nib_i,
    input  logic       en_i,
    output logic [6:0] seg_o
);

    // Plain lookup; a disabled digit drives no segments
    always_comb begin
        seg_o = 7'h00;
        if (en_i) begin
            case (nib_i)
                4'h0: seg_o = 7'h3F;
                4'h1: seg_o = 7'h06;
                4'h2: seg_o = 7'h5B;
                4'h3: seg_o = 7'h4F;
                4'h4: seg_o = 7'h66;
                4'h5: seg_o = 7'h6D;
                4'h6: seg_o = 7'h7D;
                4'h7: seg_o = 7'h07;
                4'h8: seg_o = 7'h7F;
                4'h9: seg_o = 7'h6F;
                4'hA: seg_o = 7'h77;
                4'hB: seg_o = 7'h7C;
                4'hC: seg_o = 7'h39;
                4'hD: seg_o = 7'h5E;
                4'hE: seg_o = 7'h79;
                default: seg_o = 7'h71;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: tear-free 8-digit seven-segment scanner; LEADING_ZERO_BLANK_EN blanks leading zeros
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DWELL      = 50000,
    parameter int GUARD      = 16
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);

    localparam logic [2:0]  LAST   = 3'(NUM_DIGITS - 1);
    localparam logic [15:0] DW_END = 16'(DWELL - 1);
    localparam logic [15:0] GD_END = 16'(GUARD - 1);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  an_q, an_d;
    logic [3:0]  nib_q, nib_d;
    logic        en_q, en_d, dp_q, dp_d, tick_q, tick_d;
    logic [31:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [7:0]  pend_en_q, pend_en_d, pend_dp_q, pend_dp_d;
    logic [7:0]  act_en_q, act_en_d, act_dp_q, act_dp_d;
    logic        pend_valid_q, pend_valid_d;
    logic        last, phase_end, xfer;
    logic [7:0]  xfer_en;

    assign last      = idx_q == LAST;
    assign phase_end = cnt_q == (state_q == ST_SHOW ? DW_END : GD_END);
    assign xfer      = state_q == ST_GUARD && phase_end && last;

`ifdef LEADING_ZERO_BLANK_EN
    assign xfer_en = lz_mask(pend_data_q, pend_en_q);
`else
    assign xfer_en = pend_en_q;
`endif

    // Pending/active buffers plus scan FSM; the new digit's outputs use the just-transferred buffer
    always_comb begin
        pend_data_d  = bus.load ? bus.data : pend_data_q;
        pend_en_d    = bus.load ? bus.digit_en : pend_en_q;
        pend_dp_d    = bus.load ? bus.dp_in : pend_dp_q;
        pend_valid_d = bus.load | (pend_valid_q & ~xfer);
        act_data_d   = (xfer && pend_valid_q) ? pend_data_q : act_data_q;
        act_en_d     = (xfer && pend_valid_q) ? xfer_en : act_en_q;
        act_dp_d     = (xfer && pend_valid_q) ? pend_dp_q : act_dp_q;
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = phase_end ? 16'd0 : cnt_q + 16'd1;
        an_d         = an_q;
        nib_d        = nib_q;
        en_d         = en_q;
        dp_d         = dp_q;
        tick_d       = 1'b0;
        if (phase_end && state_q == ST_SHOW) begin
            state_d = ST_GUARD;
            an_d    = AN_OFF;
            en_d    = 1'b0;
            dp_d    = 1'b0;
        end else if (phase_end) begin
            state_d = ST_SHOW;
            idx_d   = last ? 3'd0 : idx_q + 3'd1;
            an_d    = ~(8'd1 << idx_d);
            nib_d   = act_data_d[{idx_d, 2'b00} +: 4];
            en_d    = act_en_d[idx_d];
            dp_d    = act_dp_d[idx_d] & act_en_d[idx_d];
            tick_d  = last;
        end
    end

    // State register; reset parks in GUARD on the last digit so digit 0 lights first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_GUARD;
            idx_q        <= LAST;
            cnt_q        <= '0;
            an_q         <= AN_OFF;
            nib_q        <= '0;
            en_q         <= 1'b0;
            dp_q         <= 1'b0;
            tick_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_en_q    <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            act_data_q   <= '0;
            act_en_q     <= '0;
            act_dp_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            nib_q        <= nib_d;
            en_q         <= en_d;
            dp_q         <= dp_d;
            tick_q       <= tick_d;
            pend_data_q  <= pend_data_d;
            pend_en_q    <= pend_en_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            act_data_q   <= act_data_d;
            act_en_q     <= act_en_d;
            act_dp_q     <= act_dp_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

    SevenSegs u_dec (
        .nib_i (nib_q),
        .en_i  (en_q),
        .seg_o (bus.seg)
    );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed frame-table and corner-sequence bench for seg_scan_ctrl (DWELL=4, GUARD=1)
module tb_seg_scan_ctrl;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  en;
        logic [7:0]  dpi;
        logic [55:0] segs;
        logic [7:0]  dps;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   gap = 0;
    bit   seen = 1'b0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.NUM_DIGITS(8), .DWELL(4), .GUARD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input int n, input bit ld);
        for (int k = 0; k < n; k++) begin
            bus.load = ld && (k == 0);
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    task automatic wait_tick();
        for (int k = 0; k < 100 && bus.frame_tick !== 1'b1; k++) @(negedge clk);
        chk("frame_tick_wait", {31'd0, bus.frame_tick}, 32'd1);
    endtask

    task automatic show_digit(input int i, input logic [6:0] seg_e, input logic dp_e, input string tag, input bit ld);
        logic [7:0] an_e;
        an_e = ~(8'd1 << i);
        chk($sformatf("%s an d%0d", tag, i), bus.an, an_e);
        chk($sformatf("%s seg d%0d", tag, i), bus.seg, seg_e);
        chk($sformatf("%s dp d%0d", tag, i), bus.dp, dp_e);
        step(5, ld);
    endtask

    task automatic walk(input frame_t f, input string tag);
        for (int i = 0; i < 8; i++) show_digit(i, f.segs[7*i +: 7], f.dps[i], tag, 1'b0);
    endtask

    // Never two anodes low; frame_tick spacing is NUM_DIGITS*(DWELL+GUARD) = 40
    always @(negedge clk) begin
        tests++;
        if ($countones(~bus.an) > 1) begin
            fails++;
            $display("FAIL two_anodes: an=%h expected at most one low bit", bus.an);
        end
        if (rst) begin
            gap = 0;
            seen = 1'b0;
        end else begin
            gap++;
            if (bus.frame_tick === 1'b1) begin
                if (seen) chk("frame_period", gap, 32'd40);
                seen = 1'b1;
                gap = 0;
            end
        end
    end

    initial begin
        frame_t frames[6];
        frame_t blank, ones, threes;
        blank  = '{32'h0, 8'h00, 8'h00, 56'h0, 8'h00};
        ones   = '{32'h11111111, 8'hFF, 8'h00, {8{7'h06}}, 8'h00};
        threes = '{32'h33333333, 8'hFF, 8'h00, {8{7'h4F}}, 8'h00};
        frames[0] = '{32'h1234ABCD, 8'hFF, 8'h00,
                      {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h77, 7'h7C, 7'h39, 7'h5E}, 8'h00};
        frames[1] = '{32'h1234ABCD, 8'h0F, 8'h01,
                      {7'h00, 7'h00, 7'h00, 7'h00, 7'h77, 7'h7C, 7'h39, 7'h5E}, 8'h01};
        frames[2] = '{32'h76543210, 8'hFF, 8'hA5,
                      {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F}, 8'hA5};
        frames[3] = '{32'hFEDCBA98, 8'hF0, 8'hFF,
                      {7'h71, 7'h79, 7'h5E, 7'h39, 7'h00, 7'h00, 7'h00, 7'h00}, 8'hF0};
`ifdef LEADING_ZERO_BLANK_EN
        frames[4] = '{32'h000000A0, 8'hFF, 8'hFF,
                      {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h77, 7'h3F}, 8'h03};
        frames[5] = '{32'h00000000, 8'hFF, 8'hFF,
                      {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 8'h01};
`else
        frames[4] = '{32'h000000A0, 8'hFF, 8'hFF,
                      {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h77, 7'h3F}, 8'hFF};
        frames[5] = '{32'h00000000, 8'hFF, 8'hFF, {8{7'h3F}}, 8'hFF};
`endif
        bus.data = '0;
        bus.load = 1'b0;
        bus.digit_en = '0;
        bus.dp_in = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset an", bus.an, 32'hFF);
            chk("reset seg", bus.seg, 32'h0);
            chk("reset tick", {31'd0, bus.frame_tick}, 32'd0);
        end
        rst = 1'b0;
        step(1, 1'b0);
        chk("first tick", {31'd0, bus.frame_tick}, 32'd1);
        walk(blank, "blank");
        for (int f = 0; f < 6; f++) begin
            bus.data = frames[f].data;
            bus.digit_en = frames[f].en;
            bus.dp_in = frames[f].dpi;
            step(1, 1'b1);
            wait_tick();
            walk(frames[f], $sformatf("frame%0d", f));
        end
        wait_tick();
        bus.data = 32'h11111111;
        bus.digit_en = 8'hFF;
        bus.dp_in = 8'h00;
        for (int i = 0; i < 8; i++)
            show_digit(i, frames[5].segs[7*i +: 7], frames[5].dps[i], "midload old", i == 3);
        wait_tick();
        walk(ones, "midload new");
        wait_tick();
        for (int i = 0; i < 7; i++) show_digit(i, 7'h06, 1'b0, "xfer old", 1'b0);
        chk("xfer an d7", bus.an, 32'h7F);
        chk("xfer seg d7", bus.seg, 32'h06);
        step(4, 1'b0);
        bus.data = 32'h22222222;
        step(1, 1'b1);
        chk("xfer edge tick", {31'd0, bus.frame_tick}, 32'd1);
        chk("xfer edge an", bus.an, 32'hFE);
        chk("xfer edge seg", bus.seg, 32'h06);
        bus.data = 32'h33333333;
        step(1, 1'b1);
        wait_tick();
        walk(threes, "xfer second");
        bus.data = 32'h55555555;
        step(1, 1'b1);
        step(6, 1'b0);
        rst = 1'b1;
        step(2, 1'b0);
        chk("midrst an", bus.an, 32'hFF);
        chk("midrst seg", bus.seg, 32'h0);
        chk("midrst dp", {31'd0, bus.dp}, 32'd0);
        chk("midrst tick", {31'd0, bus.frame_tick}, 32'd0);
        rst = 1'b0;
        step(1, 1'b0);
        chk("post rst an", bus.an, 32'hFE);
        chk("post rst seg", bus.seg, 32'h0);
        step(1, 1'b0);
        wait_tick();
        chk("discarded pend seg", bus.seg, 32'h0);
        chk("discarded pend an", bus.an, 32'hFE);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
